// File: rtl/div_pkg.sv
// Shared definitions for the iterative signed divider.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_addsub.sv
// Combinational W-bit add/subtract: y = sub ? a - b : a + b.
// Carry-lookahead inside 4-bit groups, group carries chained between groups.
module div_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] y
);

    localparam int NG = (W + 3) / 4;

    // subtraction as a + ~b + 1, the +1 entering as the group-0 carry
    logic [W-1:0]  bo;
    logic [NG-1:0] gc;

    assign bo    = sub ? ~b : b;
    assign gc[0] = sub;

    for (genvar j = 0; j < NG; j++) begin : g_grp
        localparam int LO      = 4 * j;
        localparam int GW      = ((W - LO) < 4) ? (W - LO) : 4;
        localparam int CARRY_W = (j < NG - 1) ? GW + 1 : GW;

        logic [GW-1:0]      gg;
        logic [GW-1:0]      pp;
        logic [CARRY_W-1:0] cc;
        logic               term;
        logic               acc;

        assign gg = a[LO +: GW] & bo[LO +: GW];
        assign pp = a[LO +: GW] ^ bo[LO +: GW];

        // each carry as a flat sum of generate/propagate products
        always_comb begin
            cc   = '0;
            term = 1'b0;
            acc  = 1'b0;
            for (int k = 0; k < CARRY_W; k++) begin
                term = gc[j];
                for (int n = 0; n < k; n++) term = term & pp[n];
                acc = term;
                for (int m = 0; m < k; m++) begin
                    term = gg[m];
                    for (int n = m + 1; n < k; n++) term = term & pp[n];
                    acc = acc | term;
                end
                cc[k] = acc;
            end
        end

        assign y[LO +: GW] = pp ^ cc[GW-1:0];

        if (j < NG - 1) begin : g_cout
            assign gc[j+1] = cc[GW];
        end
    end

endmodule

// File: rtl/div_iter_signed.sv
// Iterative signed divider: non-restoring, one quotient bit per cycle.
// Magnitudes are divided unsigned, the sign is applied once at the end.
module div_iter_signed
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int CW = $clog2(WIDTH);

    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    // |x| as unsigned, so the most negative value maps onto itself
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? neg(x) : x;
    endfunction

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;

    logic [WIDTH:0]   as_a, as_b, as_y;
    logic             as_sub;

    // shifted {R,Q} is the adder input; direction follows the pre-shift remainder sign
    assign as_a   = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign as_b   = {1'b0, d_q};
    assign as_sub = ~r_q[WIDTH];

    div_addsub #(.W(WIDTH + 1)) u_addsub (
        .a   (as_a),
        .b   (as_b),
        .sub (as_sub),
        .y   (as_y)
    );

    // next-state, datapath and output control; a start pulse wins in every state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        r_d      = r_q;
        q_d      = q_q;
        d_d      = d_q;
        sign_d   = sign_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;

        if (ctrl_DIV) begin
            sign_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            d_d    = mag(data_operandB);
            q_d    = mag(data_operandA);
            r_d    = '0;
            cnt_d  = '0;
            exc_d  = (data_operandB == '0);
            if (data_operandB == '0) begin
                result_d = '0;
                state_d  = DONE;
            end else begin
                state_d  = RUN;
            end
        end else begin
            unique case (state_q)
                IDLE: ;
                RUN: begin
                    r_d   = as_y;
                    q_d   = {q_q[WIDTH-2:0], ~as_y[WIDTH]};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
                end
                FIX: begin
                    // quotient bits are exact; only the remainder would need fixing
                    result_d = sign_q ? neg(q_q) : q_q;
                    state_d  = DONE;
                end
                DONE: begin
                    rdy_d   = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // state and datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            r_q      <= '0;
            q_q      <= '0;
            d_q      <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            r_q      <= r_d;
            q_q      <= q_d;
            d_q      <= d_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule
